// File: rtl/int_ctrl.sv
// int_ctrl: collects N peripheral interrupt lines, latches their rising edges
// as pending, and presents one IRQ and one FIQ request (with the winning
// source ID) to the CPU control FSM. Each class has its own request/service
// FSM that is released by a software EOI write.

// One request/service FSM for a single interrupt class (IRQ or FIQ).
module int_ctrl_class #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   cand,
    input  logic [N-1:0]   enable,
    input  logic [N-1:0]   route,
    input  logic           inta,
    input  logic           eoi,
    output logic           req,
    output logic [IDW-1:0] id,
    output logic [N-1:0]   ack_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_SERVICE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] next_id;
    logic [IDW-1:0] win_id;
    logic           win_valid;
    logic           still_valid;

    // The presented source stays legal only while it is enabled and still routed here.
    assign still_valid = enable[id] & route[id];

    // Lowest-index candidate wins; scanning downwards leaves the lowest set bit last.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_valid = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end

    // Next-state logic; the ID is frozen while asserting, and an ack beats a withdrawal.
    always_comb begin
        next_state = state;
        next_id    = id;
        ack_clr    = '0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    next_state = ST_ASSERT;
                    next_id    = win_id;
                end
            end
            ST_ASSERT: begin
                if (inta) begin
                    ack_clr    = {{(N - 1){1'b0}}, 1'b1} << id;
                    next_state = ST_SERVICE;
                end else if (!still_valid) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register with registered request and ID outputs (ID reads 0 when not requesting).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            id    <= '0;
        end else begin
            state <= next_state;
            req   <= (next_state == ST_ASSERT);
            id    <= (next_state == ST_ASSERT) ? next_id : '0;
        end
    end

endmodule

module int_ctrl #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   src,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_addr,
    input  logic [N-1:0]   cfg_wdata,
    output logic [N-1:0]   cfg_rdata,
    input  logic           INTA_irq,
    input  logic           INTA_fiq,
    output logic           INT_irq,
    output logic           INT_fiq,
    output logic [IDW-1:0] irq_id,
    output logic [IDW-1:0] fiq_id
);

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_FIQ_SEL = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_EOI     = 2'd3;

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] sync3;
    logic [N-1:0] src_rise;

    logic [N-1:0] enable;
    logic [N-1:0] fiq_sel;
    logic [N-1:0] pending;

    logic         wr_enable;
    logic         wr_fiq_sel;
    logic         wr_pending;
    logic         wr_eoi;
    logic         eoi_irq;
    logic         eoi_fiq;
    logic [N-1:0] w1c_mask;

    logic [N-1:0] irq_route;
    logic [N-1:0] irq_cand;
    logic [N-1:0] fiq_cand;
    logic [N-1:0] irq_ack_clr;
    logic [N-1:0] fiq_ack_clr;

    // Two-flop synchronizer followed by a delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign src_rise = sync2 & ~sync3;

    assign wr_enable  = cfg_we && (cfg_addr == ADDR_ENABLE);
    assign wr_fiq_sel = cfg_we && (cfg_addr == ADDR_FIQ_SEL);
    assign wr_pending = cfg_we && (cfg_addr == ADDR_PENDING);
    assign wr_eoi     = cfg_we && (cfg_addr == ADDR_EOI);
    assign eoi_irq    = wr_eoi & cfg_wdata[0];
    assign eoi_fiq    = wr_eoi & cfg_wdata[1];
    assign w1c_mask   = wr_pending ? cfg_wdata : '0;

    // Software-visible configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable  <= '0;
            fiq_sel <= '0;
        end else begin
            if (wr_enable) begin
                enable <= cfg_wdata;
            end
            if (wr_fiq_sel) begin
                fiq_sel <= cfg_wdata;
            end
        end
    end

    // Pending latch: edges set regardless of enable and win over same-cycle W1C or ack clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~w1c_mask & ~irq_ack_clr & ~fiq_ack_clr) | src_rise;
        end
    end

    assign irq_route = ~fiq_sel;
    assign irq_cand  = pending & enable & irq_route;
    assign fiq_cand  = pending & enable & fiq_sel;

    // Combinational register readback; the EOI address has no storage behind it.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata = enable;
            ADDR_FIQ_SEL: cfg_rdata = fiq_sel;
            ADDR_PENDING: cfg_rdata = pending;
            default:      cfg_rdata = '0;
        endcase
    end

    int_ctrl_class #(
        .N   (N),
        .IDW (IDW)
    ) u_irq (
        .clk     (clk),
        .rst     (rst),
        .cand    (irq_cand),
        .enable  (enable),
        .route   (irq_route),
        .inta    (INTA_irq),
        .eoi     (eoi_irq),
        .req     (INT_irq),
        .id      (irq_id),
        .ack_clr (irq_ack_clr)
    );

    int_ctrl_class #(
        .N   (N),
        .IDW (IDW)
    ) u_fiq (
        .clk     (clk),
        .rst     (rst),
        .cand    (fiq_cand),
        .enable  (enable),
        .route   (fiq_sel),
        .inta    (INTA_fiq),
        .eoi     (eoi_fiq),
        .req     (INT_fiq),
        .id      (fiq_id),
        .ack_clr (fiq_ack_clr)
    );

endmodule
